// File: rtl/am_envelope_demod_if.sv
// Streaming ports of the AM envelope demodulator: sample input side and
// recovered-message output side.
// Valid/ready: a word moves only in a cycle where valid && ready are both high
// at the rising edge; valid may not depend on ready, and payload is held while
// valid is high and ready is low.
interface am_envelope_demod_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sample;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sample;
  logic             out_settled;

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_sample, out_settled
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_sample, out_settled
  );
endinterface

// File: rtl/am_envelope_demod.sv
// AM envelope detector: full-wave rectifier, 2^AVG_LOG2-tap moving average.
// Optional DC removal on the envelope is built when DC_BLOCK_EN is defined.
module am_envelope_demod #(
  parameter int IN_W     = 8,
  parameter int AVG_LOG2 = 4,
  parameter int OUT_W    = 8,
  parameter int DC_SHIFT = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  am_envelope_demod_if.slave bus
);
  localparam int N     = 1 << AVG_LOG2;
  localparam int ACC_W = IN_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_MAX = (AVG_LOG2 + 1)'(N);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 8 || DC_SHIFT < 1) begin : g_param_check
    $error("am_envelope_demod: AVG_LOG2 must be 1..8 and DC_SHIFT >= 1");
  end

  logic                advance;
  logic                stage2;
  logic [IN_W-1:0]     mag_q, mag_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [IN_W-1:0]     win_q [N];
  logic [IN_W-1:0]     win_d [N];
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic                settled_q, settled_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic [IN_W-1:0]     avg;
  logic [OUT_W-1:0]    out_next;

  // The whole pipeline moves together; a stalled output freezes every stage.
  assign advance = !out_valid_q || bus.out_ready;
  assign stage2  = advance && s1_valid_q;

  // Intermediate may dip below zero; the final sum never does and never overflows.
  assign acc_sum = acc_q + ACC_W'(mag_q) - ACC_W'(win_q[ptr_q]);
  assign avg     = IN_W'(acc_sum >> AVG_LOG2);

`ifdef DC_BLOCK_EN
  localparam int DC_W = IN_W + DC_SHIFT;
  localparam logic signed [IN_W+OUT_W+1:0] SAT_HI = (2 ** (OUT_W - 1)) - 1;
  localparam logic signed [IN_W+OUT_W+1:0] SAT_LO = -(2 ** (OUT_W - 1));

  logic [DC_W-1:0]              dc_q, dc_d;
  logic signed [DC_W+1:0]       dc_err;
  logic signed [IN_W+1:0]       diff;
  logic signed [IN_W+OUT_W+1:0] diff_ext, diff_al;

  // dc holds DC_SHIFT fraction bits; it tracks avg, which is never negative.
  assign dc_err   = $signed({2'b00, avg, {DC_SHIFT{1'b0}}}) - $signed({2'b00, dc_q});
  assign dc_d     = dc_q + DC_W'(dc_err >>> DC_SHIFT);
  assign diff     = $signed({2'b00, avg}) - $signed({2'b00, dc_q[DC_W-1 -: IN_W]});
  assign diff_ext = $signed({{OUT_W{diff[IN_W+1]}}, diff});

  if (OUT_W < IN_W) begin : g_dc_narrow
    assign diff_al = diff_ext >>> (IN_W - OUT_W);
  end else begin : g_dc_wide
    assign diff_al = diff_ext <<< (OUT_W - IN_W);
  end

  always_comb begin
    out_next = diff_al[OUT_W-1:0];
    if (diff_al > SAT_HI)      out_next = {1'b0, {(OUT_W-1){1'b1}}};
    else if (diff_al < SAT_LO) out_next = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dc_q <= '0;
    else if (stage2) dc_q <= dc_d;
  end
`else
  if (OUT_W < IN_W) begin : g_env_narrow
    assign out_next = avg[IN_W-1 -: OUT_W];
  end else begin : g_env_wide
    assign out_next = OUT_W'(avg) << (OUT_W - IN_W);
  end
`endif

  always_comb begin
    mag_d       = mag_q;
    s1_valid_d  = s1_valid_q;
    acc_d       = acc_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    settled_d   = settled_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (advance) begin
      // -2^(IN_W-1) negates to itself, which read unsigned is exactly 2^(IN_W-1).
      mag_d       = bus.in_sample[IN_W-1] ? IN_W'(~bus.in_sample + 1'b1) : bus.in_sample;
      s1_valid_d  = bus.in_valid;
      out_valid_d = s1_valid_q;
    end
    if (stage2) begin
      acc_d        = acc_sum;
      win_d[ptr_q] = mag_q;
      ptr_d        = ptr_q + 1'b1;
      fill_d       = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      settled_d    = settled_q || (fill_d == FILL_MAX);
      out_d        = out_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q       <= '0;
      s1_valid_q  <= 1'b0;
      acc_q       <= '0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      settled_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      mag_q       <= mag_d;
      s1_valid_q  <= s1_valid_d;
      acc_q       <= acc_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      settled_q   <= settled_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.in_ready    = advance;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sample  = out_q;
  assign bus.out_settled = settled_q;
endmodule

// File: tb/tb_am_envelope_demod.sv
// Bench for am_envelope_demod: directed ramp/rectify/edge/stall/reset cases and
// random traffic, scored against a windowed-average model of accepted samples.
module tb_am_envelope_demod;
  localparam int IN_W     = 8;
  localparam int AVG_LOG2 = 4;
  localparam int OUT_W    = 8;
  localparam int N        = 1 << AVG_LOG2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  am_envelope_demod_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  am_envelope_demod #(
    .IN_W(IN_W), .AVG_LOG2(AVG_LOG2), .OUT_W(OUT_W), .DC_SHIFT(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               mag_hist[$];
  logic [OUT_W-1:0] exp_q[$];
  bit               set_q[$];
  int               n_acc     = 0;
  int               n_checks  = 0;
  int               n_fail    = 0;
  logic [OUT_W-1:0] last_out  = '0;
  logic [OUT_W-1:0] held      = '0;
  bit               prev_stall = 1'b0;
  logic             obs_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected output = mean of |x| over the last N accepted samples, missing ones = 0.
  task automatic model_push(input logic [IN_W-1:0] s);
    int sv, sum, avg;
    sv = int'($signed(s));
    mag_hist.push_back(sv < 0 ? -sv : sv);
    if (mag_hist.size() > N) void'(mag_hist.pop_front());
    sum = 0;
    foreach (mag_hist[i]) sum += mag_hist[i];
    avg = sum / N;
    n_acc++;
    exp_q.push_back(OUT_W'((avg << OUT_W) >> IN_W));
    set_q.push_back(n_acc >= N);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [IN_W-1:0] s, input logic r);
    @(negedge clk);
    obs_valid = bus.out_valid;
    if (prev_stall) begin
      check("stall_valid_hold", bus.out_valid, 1);
      check("stall_sample_hold", bus.out_sample, held);
    end
    bus.in_valid  = v;
    bus.in_sample = s;
    bus.out_ready = r;
    #1;
    if (bus.in_valid && bus.in_ready) model_push(s);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_sample", bus.out_sample, exp_q.pop_front());
        check("out_settled", bus.out_settled, set_q.pop_front());
        last_out = bus.out_sample;
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    held       = bus.out_sample;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_settled", bus.out_settled, 0);
    check("rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    set_q.delete();
    mag_hist.delete();
    n_acc      = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;

    // Constant 100: two-cycle latency, ramp 6,12,18,25..., settle on 16th output
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 8'd100, 1'b1);
      if (i == 1)  check("lat_cycle1_idle", obs_valid, 0);
      if (i == 2)  check("lat_cycle2_valid", obs_valid, 1);
      if (i == 2)  check("ramp_1", last_out, 6);
      if (i == 3)  check("ramp_2", last_out, 12);
      if (i == 4)  check("ramp_3", last_out, 18);
      if (i == 5)  check("ramp_4", last_out, 25);
      if (i == 16) check("settled_before_16th", bus.out_settled, 0);
      if (i == 17) check("settled_at_16th", bus.out_settled, 1);
      if (i == 17) check("ramp_16", last_out, 100);
    end
    drain();

    // Alternating +100 / -100 must rectify to a flat 100
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, (i % 2 == 1) ? 8'(-100) : 8'd100, 1'b1);
    drain();
    check("rectify_steady", last_out, 100);

    // Most negative input: magnitude 128, no wrap
    do_reset();
    for (int i = 0; i < N; i++) cycle(1'b1, 8'h80, 1'b1);
    drain();
    check("edge_neg_full", last_out, 128);
    check("edge_settled", bus.out_settled, 1);

    // Back-pressure for 5 cycles in a live stream
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), !(i >= 10 && i < 15));
      if (i >= 10 && i < 15) check("stall_in_ready", bus.in_ready, 0);
    end
    drain();

    // Reset mid-stream then restart the ramp
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'd100, 1'b1);
      if (i == 2) check("post_reset_ramp", last_out, 6);
    end
    drain();

    // Random valid / ready / samples
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
